// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEFAULT_DW   = 32;
  localparam int DEFAULT_NREG = 32;

  typedef logic [$clog2(DEFAULT_NREG)-1:0] regsel_t;
  typedef logic [DEFAULT_DW-1:0]           word_t;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits; reservation beats same-cycle release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = DEFAULT_NREG,
  parameter int NWRITE = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NWRITE-1:0]                    wen,
  input  logic [NWRITE-1:0][$clog2(NREG)-1:0]  wsel,
  input  logic                                 rsv_en,
  input  logic [$clog2(NREG)-1:0]              rsv_sel,
  output logic [NREG-1:0]                      busy
);

  logic [NREG-1:0] w_next;

  // Clears are applied first so a new reservation supersedes the retiring producer.
  always_comb begin
    w_next = busy;
    for (int p = 0; p < NWRITE; p++) begin
      if (wen[p]) w_next[wsel[p]] = 1'b0;
    end
    if (rsv_en) w_next[rsv_sel] = 1'b1;
    w_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= w_next;
  end

endmodule

`default_nettype wire

// File: rtl/register_file_mp.sv
// ============================================================================
// Module      : register_file_mp
// Description : Multi-port register file, optional write bypass, busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DW     = DEFAULT_DW,
  parameter int NREG   = DEFAULT_NREG,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREAD-1:0][$clog2(NREG)-1:0]   rsel,
  output logic [NREAD-1:0][DW-1:0]             rdat,
  output logic [NREAD-1:0]                     rbusy,
  input  logic [NWRITE-1:0]                    wen,
  input  logic [NWRITE-1:0][$clog2(NREG)-1:0]  wsel,
  input  logic [NWRITE-1:0][DW-1:0]            wdat,
  input  logic                                 rsv_en,
  input  logic [$clog2(NREG)-1:0]              rsv_sel,
  output logic [NREG-1:0]                      busy
);

  logic [DW-1:0] r_regs [NREG];

  // Ascending port order: the last non-blocking write lands, so the highest port wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (wen[p] && (wsel[p] != '0)) r_regs[wsel[p]] <= wdat[p];
      end
    end
  end

  always_comb begin
    rdat = '0;
    for (int r = 0; r < NREAD; r++) begin
      if (rsel[r] != '0) begin
        rdat[r] = r_regs[rsel[r]];
        if ((BYPASS != 0) && !rst) begin
          for (int p = 0; p < NWRITE; p++) begin
            if (wen[p] && (wsel[p] == rsel[r])) rdat[r] = wdat[p];
          end
        end
      end
    end
  end

  // Busy lookup uses registered state only; a same-cycle release is not forwarded.
  always_comb begin
    rbusy = '0;
    for (int r = 0; r < NREAD; r++) rbusy[r] = busy[rsel[r]];
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .wsel    (wsel),
    .rsv_en  (rsv_en),
    .rsv_sel (rsv_sel),
    .busy    (busy)
  );

endmodule

`default_nettype wire

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port register file for the next pipelined datapath: NREAD combinational read ports and NWRITE synchronous write ports.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: the issue stage reserves a destination and the writeback stage releases it.
- Register 0 is hardwired to zero.

Parameters:
DW, 32, data width in bits
NREG, 32, number of registers; power of two, >= 2
NREAD, 2, number of read ports
NWRITE, 2, number of write ports
BYPASS, 1, 1 = read data reflects a same-cycle write; 0 = old value until the next cycle

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
rsel  input  NREAD x $clog2(NREG)  read selects, one per read port
rdat  output  NREAD x DW  read data, one per read port
rbusy  output  NREAD  busy bit of the register selected by each read port
wen  input  NWRITE  write enables
wsel  input  NWRITE x $clog2(NREG)  write selects
wdat  input  NWRITE x DW  write data
rsv_en  input  1  reserve request: mark rsv_sel busy
rsv_sel  input  $clog2(NREG)  register to reserve
busy  output  NREG  full scoreboard vector, registered

Behaviour:
- Reset (rst high at the rising edge):
  - All registers and all busy bits go to 0 at that edge.
  - While rst is high, wen and rsv_en are ignored.
  - A reset asserted mid-burst discards all writes and reservations presented in that cycle.
- Write path:
  - On the rising edge, for each port p with wen[p]=1 and wsel[p]!=0, reg[wsel[p]] <= wdat[p].
  - Writes to register 0 are dropped; reg[0] always reads as 0.
- Write collision: two or more enabled ports with the same wsel → the highest-indexed port wins, deterministically.
- Read path:
  - rdat[r] = reg[rsel[r]], combinational, zero-latency.
  - With BYPASS=1, if any enabled write port targets rsel[r] (non-zero) in the same cycle, rdat[r] returns that port's wdat, using the same highest-index priority.
  - rsel[r]=0 always yields 0, even if a write to 0 is pending.
- Scoreboard update, at each rising edge:
  - busy[i] is cleared if any enabled write port targets i.
  - busy[i] is set if rsv_en=1 and rsv_sel=i.
  - Set and clear of the same register in the same cycle: set wins; the new producer supersedes the retiring one.
  - busy[0] is never set; a reservation of register 0 is ignored.
  - A write to a non-busy register is legal: data updates, busy stays 0.
- rbusy[r] = busy[rsel[r]] from registered state, with no bypass of the same-cycle clear. Consumers must wait one cycle after writeback, or use rdat under BYPASS=1.
- Latency: write-to-read is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0. Busy set and clear are visible 1 cycle after the edge.
- No X propagation: out-of-range selects cannot occur because NREG is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - default DW and NREG constants;
  - typedef regsel_t = logic [$clog2(NREG)-1:0];
  - typedef word_t = logic [DW-1:0].
- One sub-module, regfile_scoreboard, owns the busy vector, the set/clear priority and the register-0 masking.
- Storage, write priority and the bypass muxes stay in the top module.

Test Plan:
- Reset then read all: assert rst for 2 cycles, deassert, sweep rsel[0] over 0..NREG-1 → every rdat = 0 and busy = 0.
- Dual write, distinct targets:
  - stimulus: wen=2'b11, wsel={5, 3}, wdat={0xAAAA_0005, 0x3333_0003};
  - next cycle: rsel={3, 5} → rdat={0x3333_0003, 0xAAAA_0005}.
- Write collision and register 0:
  - stimulus: both ports write reg 7, port0 = 0x1111_1111, port1 = 0x2222_2222 → reg7 = 0x2222_2222;
  - stimulus: write 0xFFFF_FFFF to reg 0 → rdat for rsel=0 stays 0.
- Bypass:
  - BYPASS=1: same cycle as wen[0]=1, wsel=9, wdat=0xDEAD_BEEF, with rsel[1]=9 → rdat[1]=0xDEAD_BEEF;
  - BYPASS=0: the same stimulus gives the old value, then 0xDEAD_BEEF next cycle.
- Scoreboard:
  - rsv_en, rsv_sel=12 → busy[12]=1 next cycle;
  - a write to 12 with a simultaneous rsv of 12 → busy[12] stays 1;
  - a later write to 12 alone → busy[12]=0;
  - rsv of 0 → busy[0] stays 0.
- Synchronous reset mid-operation: assert rst in the same cycle as wen=1 to reg 4 and rsv_en to reg 4 → reg4=0 and busy[4]=0 after the edge.
